program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 134 +++++++++++++
 tb/tb_program_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Streams a length-prefixed little-endian program into instruction memory while
// holding the CPU in reset; releases it once every word has been written.
module program_loader #(
   parameter int MEMORY_DEPTH = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [7:0]  ByteIn,
   input  logic        ByteValid,
   output logic        ByteReady,
   output logic        MemWrite,
   output logic [31:0] MemAddress,
   output logic [31:0] MemWriteData,
   output logic        CPUReset,
   output logic        Done,
   output logic        Error
);

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      DONE,
      ERROR
   } state_t;

   state_t      state, state_next;
   logic        accept;
   logic [15:0] len;
   logic [15:0] n_full;
   logic        exceed;
   logic [1:0]  byte_cnt;
   logic [15:0] word_cnt;
   logic        last_word;
   logic [23:0] word_buf;

   // Length is judged on the high byte as it arrives, before it is registered.
   always_comb begin
      n_full    = {ByteIn, len[7:0]};
      exceed    = 32'(n_full) > 32'(MEMORY_DEPTH);
      last_word = (17'(word_cnt) + 17'd1) == {1'b0, len};
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      ByteReady  = 1'b0;
      CPUReset   = 1'b1;
      Done       = 1'b0;
      Error      = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (Start) state_next = LEN_LO;
         end
         LEN_LO: begin
            ByteReady = 1'b1;
            accept    = ByteValid;
            if (accept) state_next = LEN_HI;
         end
         LEN_HI: begin
            ByteReady = 1'b1;
            accept    = ByteValid;
            if (accept) begin
               if (exceed)            state_next = ERROR;
               else if (n_full == '0) state_next = DONE;
               else                   state_next = DATA;
            end
         end
         DATA: begin
            ByteReady = 1'b1;
            accept    = ByteValid;
            if (accept && byte_cnt == 2'd3 && last_word) state_next = DONE;
         end
         DONE: begin
            CPUReset = 1'b0;
            Done     = 1'b1;
            if (Start) state_next = LEN_LO;
         end
         ERROR: begin
            Error = 1'b1;
            if (Start) state_next = LEN_LO;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         len          <= '0;
         byte_cnt     <= '0;
         word_cnt     <= '0;
         word_buf     <= '0;
         MemWrite     <= 1'b0;
         MemAddress   <= '0;
         MemWriteData <= '0;
      end else begin
         MemWrite <= 1'b0;
         case (state)
            IDLE, DONE, ERROR: begin
               if (Start) begin
                  byte_cnt <= '0;
                  word_cnt <= '0;
               end
            end
            LEN_LO: if (accept) len[7:0]  <= ByteIn;
            LEN_HI: if (accept) len[15:8] <= ByteIn;
            DATA: begin
               if (accept) begin
                  // Bytes shift in from the top so the first one ends up in [7:0].
                  if (byte_cnt == 2'd3) begin
                     MemWrite     <= 1'b1;
                     MemAddress   <= {14'b0, word_cnt, 2'b00};
                     MemWriteData <= {ByteIn, word_buf};
                     word_cnt     <= word_cnt + 16'd1;
                     byte_cnt     <= '0;
                  end else begin
                     word_buf <= {ByteIn, word_buf[23:8]};
                     byte_cnt <= byte_cnt + 2'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader: expected writes are queued per
// load and a negedge monitor matches every MemWrite against them.
module tb_program_loader;

   localparam int DEPTH = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic        Start;
   logic [7:0]  ByteIn;
   logic        ByteValid;
   logic        ByteReady;
   logic        MemWrite;
   logic [31:0] MemAddress;
   logic [31:0] MemWriteData;
   logic        CPUReset;
   logic        Done;
   logic        Error;

   program_loader #(.MEMORY_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .Start(Start), .ByteIn(ByteIn),
      .ByteValid(ByteValid), .ByteReady(ByteReady), .MemWrite(MemWrite),
      .MemAddress(MemAddress), .MemWriteData(MemWriteData),
      .CPUReset(CPUReset), .Done(Done), .Error(Error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      bit          last;
   } wr_t;

   wr_t         exp_q[$];
   int          due_q[$];
   logic [31:0] words[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every write must match the next queued expectation and its timing.
   always @(negedge clk) begin
      if (MemWrite === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", MemAddress, 32'hFFFF_FFFF);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_addr", MemAddress, e.addr);
            check("wr_data", MemWriteData, e.data);
            check("wr_ready", {31'b0, ByteReady}, {31'b0, !e.last});
            if (due_q.size() == 0) check("wr_due_missing", 32'(cyc), 32'hFFFF_FFFF);
            else                   check("wr_latency", 32'(cyc), 32'(due_q.pop_front()));
         end
      end
   end

   task automatic check_reset_state();
      check("rst_ready", {31'b0, ByteReady}, 32'd0);
      check("rst_memwrite", {31'b0, MemWrite}, 32'd0);
      check("rst_addr", MemAddress, 32'd0);
      check("rst_data", MemWriteData, 32'd0);
      check("rst_cpureset", {31'b0, CPUReset}, 32'd1);
      check("rst_done", {31'b0, Done}, 32'd0);
      check("rst_error", {31'b0, Error}, 32'd0);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      check("start_ready", {31'b0, ByteReady}, 32'd1);
      check("start_done", {31'b0, Done}, 32'd0);
      check("start_error", {31'b0, Error}, 32'd0);
      check("start_cpureset", {31'b0, CPUReset}, 32'd1);
   endtask

   // gap: 0 = back-to-back, 1 = idle cycle before every byte, 2 = random idle cycles
   task automatic send_byte(input logic [7:0] b, input int gap, input bit word_end);
      int  t;
      bit  rdy;
      bit  ok;
      if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
         @(negedge clk);
         ByteValid = 1'b0;
         ByteIn    = 8'($urandom);
      end
      t  = 0;
      ok = 0;
      while (!ok && t < 20) begin
         @(negedge clk);
         ByteIn    = b;
         ByteValid = 1'b1;
         rdy       = ByteReady;
         @(posedge clk);
         #1;
         ok = rdy;
         t++;
      end
      if (!ok) check("accept_timeout", 32'd0, 32'd1);
      else if (word_end) due_q.push_back(cyc);
   endtask

   task automatic run_load(input int n, input int gap);
      bit          err;
      int          t;
      logic [31:0] w;
      logic [15:0] n16;
      err = n > DEPTH;
      n16 = 16'(n);
      if (!err)
         for (int k = 0; k < n; k++)
            exp_q.push_back('{addr: 32'(4 * k), data: words[k], last: (k == n - 1)});
      pulse_start();
      send_byte(n16[7:0], gap, 1'b0);
      send_byte(n16[15:8], gap, 1'b0);
      if (!err)
         for (int k = 0; k < n; k++) begin
            w = words[k];
            for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], gap, b == 3);
         end
      t = 0;
      @(negedge clk);
      ByteValid = 1'b0;
      while (!(Done || Error) && t < 10) begin
         @(negedge clk);
         t++;
      end
      check("end_done", {31'b0, Done}, {31'b0, !err});
      check("end_error", {31'b0, Error}, {31'b0, err});
      check("end_cpureset", {31'b0, CPUReset}, {31'b0, err});
      check("end_ready", {31'b0, ByteReady}, 32'd0);
      // Stray bytes while finished must not be consumed or change status.
      repeat (3) begin
         @(negedge clk);
         ByteValid = 1'b1;
         ByteIn    = 8'($urandom);
      end
      @(negedge clk);
      ByteValid = 1'b0;
      check("idle_done", {31'b0, Done}, {31'b0, !err});
      check("idle_error", {31'b0, Error}, {31'b0, err});
      check("pending_writes", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic rand_words(input int n);
      words.delete();
      for (int k = 0; k < n; k++) words.push_back($urandom);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      reset     = 1'b1;
      Start     = 1'b0;
      ByteIn    = '0;
      ByteValid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_state();
      reset = 1'b0;

      words = '{32'h1234_5678, 32'hDEAD_BEEF};
      run_load(2, 0);

      run_load(DEPTH + 1, 0);

      words.delete();
      run_load(0, 0);

      words = '{32'hA5A5_0F0F};
      run_load(1, 1);

      // Abandon a load mid-word with reset, then confirm a clean reload.
      pulse_start();
      send_byte(8'h01, 0, 1'b0);
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'hAA, 0, 1'b0);
      send_byte(8'hBB, 0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      Start = 1'b1;
      @(negedge clk);
      check_reset_state();
      reset     = 1'b0;
      Start     = 1'b0;
      ByteValid = 1'b0;
      words = '{32'h0000_0001};
      run_load(1, 0);

      words = '{32'h4433_2211};
      run_load(1, 0);

      rand_words(DEPTH);
      run_load(DEPTH, 2);

      for (int i = 0; i < 6; i++) begin
         n = $urandom_range(0, DEPTH + 3);
         rand_words(n);
         run_load(n, 2);
      end

      repeat (5) @(negedge clk);
      check("final_queue", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
